// File: rtl/apb_ucpd_sync_upd_ctrl_pkg.sv
// apb_ucpd_sync_upd_ctrl_pkg: shared state encoding and width helper for the sync update sequencer
package apb_ucpd_sync_upd_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_WAIT_ACK = 2'd2} upd_st_e;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction
endpackage

// File: rtl/apb_ucpd_sync_tmr.sv
// apb_ucpd_sync_tmr: loadable down-counter that saturates at zero and flags it
module apb_ucpd_sync_tmr #(
  parameter int W = 8
) (
  input  logic         pclk,
  input  logic         presetn,
  input  logic         clr,
  input  logic         ld,
  input  logic         en,
  input  logic [W-1:0] ld_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) cnt <= '0;
    else cnt <= clr ? '0 : ld ? ld_val : (en && cnt != '0) ? cnt - W'(1) : cnt;
  assign zero = cnt == '0;
endmodule

// File: rtl/apb_ucpd_sync_upd_ctrl.sv
// apb_ucpd_sync_upd_ctrl: holds each published value for a fixed window, coalesces writes, optional ack wait
module apb_ucpd_sync_upd_ctrl
  import apb_ucpd_sync_upd_ctrl_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter int               HOLD_CYC = 4,
  parameter bit               ACK_EN   = 1'b0,
  parameter int               TMO_CYC  = 255
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             init_n,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] data_s,
  output logic             upd_tgl,
  input  logic             ack_tgl_sync,
  output logic             wr_busy,
  output logic             pend,
  output logic             done,
  output logic             tmo_err
);
  localparam int HW = clog2(HOLD_CYC + 1);
  localparam int TW = clog2(TMO_CYC + 1);
  upd_st_e state;
  logic [WIDTH-1:0] pend_buf;
  logic hold_zero, tmo_zero, ack_match, to_wait, complete, timeout, publish;
  always_comb begin
    ack_match = ack_tgl_sync == upd_tgl;
    to_wait   = state == ST_HOLD && hold_zero && ACK_EN;
    complete  = (state == ST_HOLD && hold_zero && !ACK_EN) ||
                (state == ST_WAIT_ACK && (ack_match || tmo_zero));
    timeout   = state == ST_WAIT_ACK && tmo_zero && !ack_match;
    publish   = (state == ST_IDLE && wr_req) || (complete && (wr_req || pend));
  end
  assign wr_busy = state != ST_IDLE;
  apb_ucpd_sync_tmr #(.W(HW)) u_hold (
    .pclk, .presetn, .clr(!init_n), .ld(publish), .en(state == ST_HOLD),
    .ld_val(HW'(HOLD_CYC - 1)), .zero(hold_zero)
  );
  apb_ucpd_sync_tmr #(.W(TW)) u_tmo (
    .pclk, .presetn, .clr(!init_n), .ld(to_wait), .en(state == ST_WAIT_ACK),
    .ld_val(TW'(TMO_CYC - 1)), .zero(tmo_zero)
  );
  // a write in the completion cycle is published straight away and supersedes pend_buf
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      state    <= ST_IDLE;
      data_s   <= RST_VAL;
      upd_tgl  <= 1'b0;
      pend     <= 1'b0;
      pend_buf <= '0;
      done     <= 1'b0;
      tmo_err  <= 1'b0;
    end else if (!init_n) begin
      state    <= ST_IDLE;
      data_s   <= RST_VAL;
      upd_tgl  <= 1'b0;
      pend     <= 1'b0;
      pend_buf <= '0;
      done     <= 1'b0;
      tmo_err  <= 1'b0;
    end else begin
      done    <= complete;
      tmo_err <= timeout;
      if (publish) begin
        data_s  <= wr_req ? wr_data : pend_buf;
        upd_tgl <= !upd_tgl;
        state   <= ST_HOLD;
        pend    <= 1'b0;
      end else if (complete) state <= ST_IDLE;
      else if (to_wait) state <= ST_WAIT_ACK;
      if (wr_req && !publish) begin
        pend     <= 1'b1;
        pend_buf <= wr_data;
      end
    end
endmodule

// File: tb/tb_apb_ucpd_sync_upd_ctrl.sv
// tb_apb_ucpd_sync_upd_ctrl: scoreboard bench, one instance without and one with ack handshake
module tb_apb_ucpd_sync_upd_ctrl;
  logic pclk = 1'b0, presetn = 1'b0, init_n = 1'b1, ini_q = 1'b0;
  logic wr0 = 1'b0, wr1 = 1'b0, ack0 = 1'b0, ack1 = 1'b0;
  logic [7:0] wd0 = '0, wd1 = '0, d0, d1;
  logic tgl0, tgl1, busy0, busy1, pend0, pend1, done0, done1, tmo0, tmo1;
  logic last0 = 1'b0, last1 = 1'b0;
  int nvec = 0, nerr = 0, ndone0 = 0, ntmo1 = 0, n, base;
  logic [7:0] q0[$], q1[$];

  always #5 pclk = ~pclk;

  apb_ucpd_sync_upd_ctrl #(.WIDTH(8), .RST_VAL(8'hA5), .HOLD_CYC(4), .ACK_EN(1'b0), .TMO_CYC(255)) u0 (
    .pclk(pclk), .presetn(presetn), .init_n(init_n), .wr_req(wr0), .wr_data(wd0), .data_s(d0),
    .upd_tgl(tgl0), .ack_tgl_sync(ack0), .wr_busy(busy0), .pend(pend0), .done(done0), .tmo_err(tmo0)
  );
  apb_ucpd_sync_upd_ctrl #(.WIDTH(8), .RST_VAL(8'hA5), .HOLD_CYC(4), .ACK_EN(1'b1), .TMO_CYC(8)) u1 (
    .pclk(pclk), .presetn(presetn), .init_n(init_n), .wr_req(wr1), .wr_data(wd1), .data_s(d1),
    .upd_tgl(tgl1), .ack_tgl_sync(ack1), .wr_busy(busy1), .pend(pend1), .done(done1), .tmo_err(tmo1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  always @(posedge pclk) ini_q <= presetn & init_n;

  // every upd_tgl flip outside reset is one publish; it must match the oldest expected value
  always @(negedge pclk) begin
    logic [7:0] e;
    if (!ini_q) last0 <= tgl0;
    else if (tgl0 != last0) begin
      last0 <= tgl0;
      if (q0.size() != 0) e = q0.pop_front(); else e = 'x;
      chk("pub0", d0, e);
    end
    if (!ini_q) last1 <= tgl1;
    else if (tgl1 != last1) begin
      last1 <= tgl1;
      if (q1.size() != 0) e = q1.pop_front(); else e = 'x;
      chk("pub1", d1, e);
    end
    if (done0) ndone0 <= ndone0 + 1;
    if (tmo1) ntmo1 <= ntmo1 + 1;
  end

  task automatic wait_done0(output int cnt);
    cnt = 0;
    do begin cyc(); cnt++; end while (!done0 && cnt < 20);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) cyc();
    chk("rst_d0", d0, 8'hA5);
    chk("rst_d1", d1, 8'hA5);
    chk("rst_flags0", {tgl0, busy0, pend0, done0, tmo0}, 5'b0);
    chk("rst_flags1", {tgl1, busy1, pend1, done1, tmo1}, 5'b0);
    presetn = 1'b1;
    cyc();
    // basic publish, one-cycle latency, hold of 4
    wr0 = 1'b1; wd0 = 8'h3C; q0.push_back(8'h3C);
    cyc();
    wr0 = 1'b0;
    chk("t1_d", d0, 8'h3C);
    chk("t1_tgl", tgl0, 1'b1);
    chk("t1_busy", busy0, 1'b1);
    wait_done0(n);
    chk("t1_hold", n, 4);
    chk("t1_idle", busy0, 1'b0);
    // coalescing: 8'h22 is overwritten by 8'h33
    base = ndone0;
    wr0 = 1'b1; wd0 = 8'h11; q0.push_back(8'h11);
    cyc();
    chk("t2_d_e0", d0, 8'h11);
    wd0 = 8'h22;
    cyc();
    chk("t2_d_e1", d0, 8'h11);
    chk("t2_pend", pend0, 1'b1);
    wd0 = 8'h33; q0.push_back(8'h33);
    cyc();
    chk("t2_d_e2", d0, 8'h11);
    wr0 = 1'b0;
    cyc();
    chk("t2_d_e3", d0, 8'h11);
    chk("t2_nodone", done0, 1'b0);
    cyc();
    chk("t2_d_e4", d0, 8'h33);
    chk("t2_done", done0, 1'b1);
    chk("t2_pend_clr", pend0, 1'b0);
    chk("t2_busy", busy0, 1'b1);
    wait_done0(n);
    chk("t2_hold2", n, 4);
    chk("t2_ndone", ndone0 - base, 2);
    chk("t2_tgl", tgl0, 1'b1);
    // write in the completion cycle beats the pending value
    wr0 = 1'b1; wd0 = 8'h44; q0.push_back(8'h44);
    cyc();
    wd0 = 8'h55;
    cyc();
    wr0 = 1'b0;
    cyc();
    cyc();
    wr0 = 1'b1; wd0 = 8'h66; q0.push_back(8'h66);
    cyc();
    wr0 = 1'b0;
    chk("t5_d", d0, 8'h66);
    chk("t5_pend", pend0, 1'b0);
    chk("t5_done", done0, 1'b1);
    chk("t5_busy", busy0, 1'b1);
    wait_done0(n);
    chk("t5_hold", n, 4);
    // ack arrives six cycles after the publish
    wr1 = 1'b1; wd1 = 8'h5A; q1.push_back(8'h5A);
    cyc();
    wr1 = 1'b0;
    repeat (4) cyc();
    chk("t3_wait", busy1, 1'b1);
    chk("t3_nodone", done1, 1'b0);
    repeat (2) cyc();
    ack1 = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!done1 && n < 20);
    chk("t3_done_lat", n, 1);
    chk("t3_idle", busy1, 1'b0);
    chk("t3_notmo", ntmo1, 0);
    // ack stuck: timeout 8 cycles after entering WAIT_ACK
    wr1 = 1'b1; wd1 = 8'hC3; q1.push_back(8'hC3);
    cyc();
    wr1 = 1'b0;
    repeat (4) cyc();
    chk("t4_wait", busy1, 1'b1);
    n = 0;
    do begin cyc(); n++; end while (!tmo1 && n < 20);
    chk("t4_tmo_lat", n, 8);
    chk("t4_done", done1, 1'b1);
    chk("t4_idle", busy1, 1'b0);
    cyc();
    chk("t4_pulse", tmo1, 1'b0);
    chk("t4_ntmo", ntmo1, 1);
    // init_n during hold with a pending value abandons everything
    wr0 = 1'b1; wd0 = 8'h77; q0.push_back(8'h77);
    cyc();
    wd0 = 8'h88;
    cyc();
    chk("t6_pend", pend0, 1'b1);
    wr0 = 1'b0; init_n = 1'b0;
    base = ndone0;
    cyc();
    init_n = 1'b1;
    chk("t6_d", d0, 8'hA5);
    chk("t6_flags", {tgl0, busy0, pend0, done0}, 4'b0);
    repeat (8) cyc();
    chk("t6_nodone", ndone0 - base, 0);
    chk("t6_idle", busy0, 1'b0);
    chk("t6_d_kept", d0, 8'hA5);
    // same value as data_s is still published
    wr0 = 1'b1; wd0 = 8'hA5; q0.push_back(8'hA5);
    cyc();
    wr0 = 1'b0;
    chk("t7_tgl", tgl0, 1'b1);
    wait_done0(n);
    chk("t7_hold", n, 4);
    cyc();
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
